// File: rtl/datapath_sequencer_if.sv
// rtl/datapath_sequencer_if.sv - instruction handshake and datapath control bundle
interface datapath_sequencer_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
);
  logic [15:0]           instr;
  logic                  s;
  logic                  w;
  logic                  err;
  logic [REG_ADDR_W-1:0] readnum;
  logic [REG_ADDR_W-1:0] writenum;
  logic                  loada;
  logic                  loadb;
  logic                  asel;
  logic                  bsel;
  logic [1:0]            shift;
  logic [1:0]            ALUop;
  logic                  loadc;
  logic                  loads;
  logic                  write;
  logic                  vsel;
  logic [DATA_W-1:0]     datapath_in;

  modport master (
    output instr, s,
    input  w, err, readnum, writenum, loada, loadb, asel, bsel,
           shift, ALUop, loadc, loads, write, vsel, datapath_in
  );

  modport slave (
    input  instr, s,
    output w, err, readnum, writenum, loada, loadb, asel, bsel,
           shift, ALUop, loadc, loads, write, vsel, datapath_in
  );
endinterface

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - Moore sequencer driving the register-file/ALU datapath
module datapath_sequencer #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  datapath_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {WAIT, DECODE, WIMM, GETA, GETB, EXEC, WBACK} state_t;

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic        err_q;

  logic [2:0] opcode;
  logic [1:0] op;
  logic       mov_imm, mov_reg, is_alu, is_mvn, is_cmp, illegal;

  assign opcode  = ir[15:13];
  assign op      = ir[12:11];
  assign mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign illegal = !(mov_imm || mov_reg || is_alu);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT;
      ir    <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // err is registered so it shows up in WAIT, one cycle after DECODE
      err_q <= (state == DECODE) && illegal;
      if (state == WAIT && bus.s)
        ir <= bus.instr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:    state_nxt = bus.s ? DECODE : WAIT;
      DECODE: begin
        if (mov_imm)                 state_nxt = WIMM;
        else if (mov_reg || is_mvn)  state_nxt = GETB;
        else if (is_alu)             state_nxt = GETA;
        else                         state_nxt = WAIT;
      end
      WIMM:    state_nxt = WAIT;
      GETA:    state_nxt = GETB;
      GETB:    state_nxt = EXEC;
      EXEC:    state_nxt = is_cmp ? WAIT : WBACK;
      WBACK:   state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  logic [REG_ADDR_W-1:0] readnum_c, writenum_c;
  logic [1:0]            shift_c, aluop_c;
  logic                  loada_c, loadb_c, asel_c, loadc_c, loads_c, write_c, vsel_c;

  always_comb begin
    readnum_c  = '0;
    writenum_c = '0;
    shift_c    = 2'b00;
    aluop_c    = 2'b00;
    loada_c    = 1'b0;
    loadb_c    = 1'b0;
    asel_c     = 1'b0;
    loadc_c    = 1'b0;
    loads_c    = 1'b0;
    write_c    = 1'b0;
    vsel_c     = 1'b0;
    case (state)
      WIMM: begin
        writenum_c = ir[10:8];
        vsel_c     = 1'b1;
        write_c    = 1'b1;
      end
      GETA: begin
        readnum_c = ir[10:8];
        loada_c   = 1'b1;
      end
      GETB: begin
        readnum_c = ir[2:0];
        loadb_c   = 1'b1;
      end
      EXEC: begin
        shift_c = ir[4:3];
        // zeroing A turns the add/not-B ALU into a pass-through of shifted B
        asel_c  = mov_reg || is_mvn;
        aluop_c = is_alu ? op : 2'b00;
        loads_c = is_cmp;
        loadc_c = !is_cmp;
      end
      WBACK: begin
        writenum_c = ir[7:5];
        write_c    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.w           = (state == WAIT);
  assign bus.err         = err_q;
  assign bus.readnum     = readnum_c;
  assign bus.writenum    = writenum_c;
  assign bus.loada       = loada_c;
  assign bus.loadb       = loadb_c;
  assign bus.asel        = asel_c;
  assign bus.bsel        = 1'b0;
  assign bus.shift       = shift_c;
  assign bus.ALUop       = aluop_c;
  assign bus.loadc       = loadc_c;
  assign bus.loads       = loads_c;
  assign bus.write       = write_c;
  assign bus.vsel        = vsel_c;
  assign bus.datapath_in = {{(DATA_W-8){ir[7]}}, ir[7:0]};
endmodule
